// File: rtl/lif_tdm_scheduler_if.sv
// Current-fetch and update-record bundle between the LIF scheduler and its neighbours.
// master = scheduler side (drives the request and the update record), slave = accumulator/monitor side.
interface lif_tdm_scheduler_if #(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_W      = 4
);
  logic                   o_cur_req;
  logic [ADDR_W-1:0]      o_cur_addr;
  logic                   i_cur_valid;
  logic [DATA_LENGTH-1:0] i_cur_data;
  logic                   o_upd_valid;
  logic [ADDR_W-1:0]      o_upd_addr;
  logic [DATA_LENGTH-1:0] o_upd_state;
  logic                   o_upd_spike;

  modport master (
    output o_cur_req, o_cur_addr,
    input  i_cur_valid, i_cur_data,
    output o_upd_valid, o_upd_addr, o_upd_state, o_upd_spike
  );

  modport slave (
    input  o_cur_req, o_cur_addr,
    output i_cur_valid, i_cur_data,
    input  o_upd_valid, o_upd_addr, o_upd_state, o_upd_spike
  );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// Sweeps N_NEURONS virtual LIF neurons per tick through one update datapath; update record one cycle after accept.
// Fetch address holds until i_cur_valid; a stall of k cycles delays the sweep by k cycles, nothing is dropped.
module lif_tdm_scheduler #(
  parameter int DATA_LENGTH = 32,
  parameter int N_NEURONS   = 16,
  parameter int ADDR_W      = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_tick,
  input  logic                   i_cfg_we,
  input  logic [1:0]             i_cfg_sel,
  input  logic [DATA_LENGTH-1:0] i_cfg_data,
  lif_tdm_scheduler_if.master    bus,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overrun
);

  localparam int SW = DATA_LENGTH + 2;
  localparam logic [ADDR_W-1:0]      LAST_IDX = ADDR_W'(N_NEURONS - 1);
  localparam logic [DATA_LENGTH-1:0] THR_DEF  = DATA_LENGTH'(32'd2147483647);
  localparam logic [DATA_LENGTH-1:0] REST_DEF = DATA_LENGTH'(32'd900000);
  localparam logic [DATA_LENGTH-1:0] DEC_DEF  = DATA_LENGTH'(32'd800000);

  typedef enum logic [1:0] {IDLE, FETCH, FINISH} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [DATA_LENGTH-1:0] mem_q [N_NEURONS];
  logic [DATA_LENGTH-1:0] thr_q, rest_q, dec_q;

  logic                   upd_valid_q, upd_spike_q, overrun_q;
  logic [ADDR_W-1:0]      upd_addr_q;
  logic [DATA_LENGTH-1:0] upd_state_q;

  logic                   accept;
  logic [DATA_LENGTH-1:0] cur_v, new_v;
  logic                   new_spike;
  logic signed [SW-1:0]   v_s, rest_s, dec_s, i_s, sum_s;

  assign accept = (state_q == FETCH) && bus.i_cur_valid;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (i_tick) begin
          state_d = FETCH;
          idx_d   = '0;
        end
      end
      FETCH: begin
        if (accept) begin
          if (idx_q == LAST_IDX) state_d = FINISH;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands widened by two bits so rest+I and v-dec+I never wrap before clamping.
  assign cur_v  = mem_q[idx_q];
  assign v_s    = $signed({2'b00, cur_v});
  assign rest_s = $signed({2'b00, rest_q});
  assign dec_s  = $signed({2'b00, dec_q});
  assign i_s    = $signed({2'b00, bus.i_cur_data});

  always_comb begin
    new_spike = 1'b0;
    sum_s     = rest_s;
    new_v     = '0;
    if (cur_v >= thr_q)       new_spike = 1'b1;
    else if (cur_v <= rest_q) sum_s = rest_s + i_s;
    else                      sum_s = v_s - dec_s + i_s;

    if (sum_s[SW-1])      new_v = '0;
    else if (sum_s[SW-2]) new_v = '1;
    else                  new_v = sum_s[DATA_LENGTH-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      thr_q       <= THR_DEF;
      rest_q      <= REST_DEF;
      dec_q       <= DEC_DEF;
      upd_valid_q <= 1'b0;
      upd_addr_q  <= '0;
      upd_state_q <= '0;
      upd_spike_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int n = 0; n < N_NEURONS; n++) mem_q[n] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      upd_valid_q <= accept;
      overrun_q   <= i_tick && (state_q != IDLE);
      if (accept) begin
        mem_q[idx_q] <= new_v;
        upd_addr_q   <= idx_q;
        upd_state_q  <= new_v;
        upd_spike_q  <= new_spike;
      end
      // Configuration is frozen while a sweep is using it.
      if (state_q == IDLE && i_cfg_we) begin
        case (i_cfg_sel)
          2'd0:    thr_q  <= i_cfg_data;
          2'd1:    rest_q <= i_cfg_data;
          2'd2:    dec_q  <= i_cfg_data;
          default: ;
        endcase
      end
    end
  end

  assign bus.o_cur_req   = (state_q == FETCH);
  assign bus.o_cur_addr  = idx_q;
  assign bus.o_upd_valid = upd_valid_q;
  assign bus.o_upd_addr  = upd_addr_q;
  assign bus.o_upd_state = upd_state_q;
  assign bus.o_upd_spike = upd_spike_q;
  assign o_busy          = (state_q == FETCH);
  assign o_done          = (state_q == FINISH);
  assign o_overrun       = overrun_q;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Randomised and directed bench for lif_tdm_scheduler with a queue scoreboard and an arithmetic LIF model.
module tb_lif_tdm_scheduler;
  localparam int DL = 32;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam longint MAXV = 64'd4294967295;

  logic i_clk, i_rst_n, i_tick, i_cfg_we;
  logic [1:0] i_cfg_sel;
  logic [DL-1:0] i_cfg_data;
  logic o_busy, o_done, o_overrun;

  lif_tdm_scheduler_if #(.DATA_LENGTH(DL), .ADDR_W(AW)) bus ();

  lif_tdm_scheduler #(.DATA_LENGTH(DL), .N_NEURONS(N), .ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick),
    .i_cfg_we(i_cfg_we), .i_cfg_sel(i_cfg_sel), .i_cfg_data(i_cfg_data),
    .bus(bus), .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  typedef struct { int addr; longint st; bit spk; bit last; } exp_t;
  exp_t sb[$];

  longint m_mem [N];
  longint m_thr, m_rest, m_dec;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < N; n++) m_mem[n] = 0;
    m_thr = 2147483647; m_rest = 900000; m_dec = 800000;
  endtask

  task automatic model_cfg(input logic [1:0] sel, input longint d);
    case (sel)
      2'd0: m_thr = d;
      2'd1: m_rest = d;
      2'd2: m_dec = d;
      default: ;
    endcase
  endtask

  // Leaky integrate-and-fire rule evaluated with wide integers, then clamped to the word range.
  task automatic push_exp(input int k, input longint c);
    exp_t e; longint v, r;
    v = m_mem[k];
    if (v >= m_thr)       begin r = m_rest;         e.spk = 1'b1; end
    else if (v <= m_rest) begin r = m_rest + c;     e.spk = 1'b0; end
    else                  begin r = v - m_dec + c;  e.spk = 1'b0; end
    if (r < 0) r = 0;
    else if (r > MAXV) r = MAXV;
    m_mem[k] = r;
    e.addr = k; e.st = r; e.last = (k == N-1);
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every update record must match the oldest expectation.
  always @(negedge i_clk) begin : monitor
    exp_t e;
    if (bus.o_upd_valid) begin
      if (sb.size() == 0) chk(1'b0, "upd_unexpected", longint'(bus.o_upd_addr), -1);
      else begin
        e = sb.pop_front();
        chk(int'(bus.o_upd_addr) == e.addr, "upd_addr", longint'(bus.o_upd_addr), e.addr);
        chk(longint'(bus.o_upd_state) == e.st, "upd_state", longint'(bus.o_upd_state), e.st);
        chk(bus.o_upd_spike == e.spk, "upd_spike", longint'(bus.o_upd_spike), longint'(e.spk));
        chk(o_done == e.last, "done_with_last", longint'(o_done), longint'(e.last));
      end
    end else begin
      chk(o_done == 1'b0, "done_spurious", longint'(o_done), 0);
    end
  end

  task automatic cfg_write(input logic [1:0] sel, input longint d);
    i_cfg_we = 1'b1; i_cfg_sel = sel; i_cfg_data = DL'(d);
    model_cfg(sel, d);
    @(posedge i_clk); @(negedge i_clk);
    i_cfg_we = 1'b0;
  endtask

  // cur<0: random currents; stall_at=-2: random stalls; ovr_at=N: tick during FINISH.
  task automatic sweep(input longint cur, input int stall_at, input int stall_len, input int ovr_at,
                       input int lock_at, input bit tcfg, input logic [1:0] tsel, input longint tdat);
    int k = 0; int guard = 0; int sl = stall_len;
    bit ovr_pend = 1'b0; bit ovr_done = 1'b0; bit lock_done = 1'b0; bit take;
    longint c;
    i_tick = 1'b1;
    if (tcfg) begin
      i_cfg_we = 1'b1; i_cfg_sel = tsel; i_cfg_data = DL'(tdat);
      model_cfg(tsel, tdat);
    end
    @(posedge i_clk); @(negedge i_clk);
    while (k < N) begin
      guard++;
      if (guard > 64) begin chk(1'b0, "sweep_timeout", k, N); break; end
      i_tick = 1'b0; i_cfg_we = 1'b0;
      chk(o_overrun == ovr_pend, "overrun", longint'(o_overrun), longint'(ovr_pend));
      ovr_pend = 1'b0;
      chk(bus.o_cur_req == 1'b1, "cur_req", longint'(bus.o_cur_req), 1);
      chk(o_busy == 1'b1, "busy", longint'(o_busy), 1);
      chk(bus.o_cur_addr == AW'(k), "cur_addr", longint'(bus.o_cur_addr), k);
      if (!bus.o_cur_req) begin bus.i_cur_valid = 1'b0; break; end
      if (k == ovr_at && !ovr_done) begin i_tick = 1'b1; ovr_done = 1'b1; ovr_pend = 1'b1; end
      if (k == lock_at && !lock_done) begin
        i_cfg_we = 1'b1; i_cfg_sel = 2'd0; i_cfg_data = DL'(5); lock_done = 1'b1;
      end
      take = 1'b1;
      if (stall_at == -2) take = ($urandom_range(0, 3) != 0);
      else if (k == stall_at && sl > 0) begin take = 1'b0; sl--; end
      if (take) begin
        c = (cur < 0) ? longint'($urandom_range(0, 800)) : cur;
        bus.i_cur_valid = 1'b1; bus.i_cur_data = DL'(c);
        push_exp(k, c);
        k++;
      end else begin
        bus.i_cur_valid = 1'b0; bus.i_cur_data = $urandom;
      end
      @(posedge i_clk); @(negedge i_clk);
    end
    bus.i_cur_valid = 1'b0; i_cfg_we = 1'b0;
    i_tick = (ovr_at == N);
    chk(o_overrun == ovr_pend, "overrun_last", longint'(o_overrun), longint'(ovr_pend));
    chk(bus.o_cur_req == 1'b0, "finish_req", longint'(bus.o_cur_req), 0);
    chk(o_busy == 1'b0, "finish_busy", longint'(o_busy), 0);
    @(posedge i_clk); @(negedge i_clk);
    i_tick = 1'b0;
    chk(o_overrun == (ovr_at == N), "finish_tick_ovr", longint'(o_overrun), longint'(ovr_at == N));
    chk(o_busy == 1'b0, "idle_busy", longint'(o_busy), 0);
    chk(bus.o_cur_req == 1'b0, "idle_req", longint'(bus.o_cur_req), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk(bus.o_cur_req == 1'b0, {tag, "_cur_req"}, longint'(bus.o_cur_req), 0);
    chk(bus.o_cur_addr == '0, {tag, "_cur_addr"}, longint'(bus.o_cur_addr), 0);
    chk(bus.o_upd_valid == 1'b0, {tag, "_upd_valid"}, longint'(bus.o_upd_valid), 0);
    chk(bus.o_upd_addr == '0, {tag, "_upd_addr"}, longint'(bus.o_upd_addr), 0);
    chk(bus.o_upd_state == '0, {tag, "_upd_state"}, longint'(bus.o_upd_state), 0);
    chk(bus.o_upd_spike == 1'b0, {tag, "_upd_spike"}, longint'(bus.o_upd_spike), 0);
    chk(o_busy == 1'b0, {tag, "_busy"}, longint'(o_busy), 0);
    chk(o_done == 1'b0, {tag, "_done"}, longint'(o_done), 0);
    chk(o_overrun == 1'b0, {tag, "_overrun"}, longint'(o_overrun), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    longint c;
    int ovr, lck, nw;
    logic [1:0] sel;
    i_rst_n = 1'b1; i_tick = 1'b0; i_cfg_we = 1'b0; i_cfg_sel = '0; i_cfg_data = '0;
    bus.i_cur_valid = 1'b0; bus.i_cur_data = '0;
    model_reset();
    #2 i_rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Threshold crossing over three sweeps: 60, 105, then spike back to rest.
    cfg_write(2'd0, 100); cfg_write(2'd1, 10); cfg_write(2'd2, 5);
    repeat (3) sweep(50, -1, 0, -1, -1, 1'b0, 2'd0, 0);
    sweep(50, 2, 3, -1, -1, 1'b0, 2'd0, 0);
    sweep(50, -1, 0, 1, -1, 1'b0, 2'd0, 0);
    repeat (3) begin
      @(negedge i_clk);
      chk(o_busy == 1'b0, "no_second_sweep", longint'(o_busy), 0);
    end
    sweep(0, -1, 0, N, -1, 1'b0, 2'd0, 0);
    // Mid-sweep threshold write must be ignored; idle write then applies.
    sweep(0, -1, 0, -1, 1, 1'b0, 2'd0, 0);
    sweep(0, -1, 0, -1, -1, 1'b0, 2'd0, 0);
    cfg_write(2'd0, 5);
    sweep(0, -1, 0, -1, -1, 1'b0, 2'd0, 0);
    sweep(50, -1, 0, -1, -1, 1'b1, 2'd0, 100);
    cfg_write(2'd3, 7);

    // Saturation at the top of the range, then underflow to zero.
    cfg_write(2'd0, MAXV); cfg_write(2'd1, 64'hFFFF_FF00);
    sweep(0, -1, 0, -1, -1, 1'b0, 2'd0, 0);
    cfg_write(2'd1, 0); cfg_write(2'd2, 0);
    sweep(64'h1000, -1, 0, -1, -1, 1'b0, 2'd0, 0);
    cfg_write(2'd1, 20);
    sweep(0, -1, 0, -1, -1, 1'b0, 2'd0, 0);
    cfg_write(2'd1, 10); cfg_write(2'd2, 50);
    sweep(0, -1, 0, -1, -1, 1'b0, 2'd0, 0);

    for (int s = 0; s < 25; s++) begin
      nw = int'($urandom_range(0, 2));
      for (int w = 0; w < nw; w++) cfg_write(2'($urandom_range(0, 3)), longint'($urandom_range(0, 3000)));
      ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N)) : -1;
      lck = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N-1)) : -1;
      sel = 2'($urandom_range(0, 3));
      sweep(-1, -2, 0, ovr, lck, ($urandom_range(0, 3) == 0), sel, longint'($urandom_range(0, 3000)));
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
    end

    // Asynchronous reset between edges while neuron 2 is being updated.
    i_tick = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk(bus.o_cur_addr == AW'(k), "rst_pre_addr", longint'(bus.o_cur_addr), k);
      c = longint'($urandom_range(1, 800));
      bus.i_cur_valid = 1'b1; bus.i_cur_data = DL'(c);
      push_exp(k, c);
      @(posedge i_clk);
      if (k < 2) @(negedge i_clk);
    end
    #2 i_rst_n = 1'b0;
    sb.delete();
    model_reset();
    bus.i_cur_valid = 1'b0;
    #1 check_outputs_zero("async_rst");
    @(negedge i_clk); @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (N + 3) @(negedge i_clk);
    sweep(-1, -1, 0, -1, -1, 1'b0, 2'd0, 0);
    sweep(-1, -1, 0, -1, -1, 1'b0, 2'd0, 0);

    repeat (3) @(negedge i_clk);
    chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lif_tdm_scheduler.md
Name: lif_tdm_scheduler

Overview:
- Time-multiplexes one LIF membrane-update datapath across N_NEURONS virtual neurons.
- On each timestep tick it sweeps the neuron indices, fetches one input current per neuron over a request/valid handshake, applies the LIF rule, stores the new state and emits an update record.
- Sits between the synaptic-current accumulator, which is upstream, and the spike router/monitor, which is downstream.
- Also owns the runtime threshold, resting-voltage and decay configuration.

Parameters:
- DATA_LENGTH, 32, width of membrane state, current and configuration words.
- N_NEURONS, 16, number of virtual neurons; must be ≥2.
- ADDR_W, 4, neuron index width; must be ≥ clog2(N_NEURONS).

Ports:
- i_clk  in  1  single clock; all logic is on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_tick  in  1  timestep start pulse.
- o_cur_req  out  1  requests the current for neuron o_cur_addr.
- o_cur_addr  out  ADDR_W  index of the neuron being fetched.
- i_cur_valid  in  1  current is valid; the current is accepted in any cycle where o_cur_req && i_cur_valid.
- i_cur_data  in  DATA_LENGTH  unsigned input current.
- i_cfg_we  in  1  configuration write strobe.
- i_cfg_sel  in  2  configuration target: 0 = threshold, 1 = resting voltage, 2 = decay, 3 = reserved (write ignored).
- i_cfg_data  in  DATA_LENGTH  configuration value.
- o_upd_valid  out  1  one-cycle pulse per neuron update.
- o_upd_addr  out  ADDR_W  index of the updated neuron.
- o_upd_state  out  DATA_LENGTH  new membrane state.
- o_upd_spike  out  1  the neuron fired on this update.
- o_busy  out  1  a sweep is in progress.
- o_done  out  1  one-cycle pulse when a sweep completes.
- o_overrun  out  1  one-cycle pulse when a tick arrives while busy.

Behaviour:
- Reset (asynchronous, any time, including mid-sweep):
  - All membrane states go to 0 and the index goes to 0. The FSM goes to IDLE.
  - All outputs go to 0.
  - Configuration returns to defaults: threshold 2147483647, resting voltage 900000, decay 800000.
  - Any sweep in progress is abandoned with no o_done.
- FSM states are IDLE, FETCH and FINISH.
- IDLE:
  - i_tick moves the FSM to FETCH with idx=0.
  - o_cur_req rises in the cycle after the tick edge.
- FETCH:
  - o_cur_req=1, o_cur_addr=idx, o_busy=1.
  - o_cur_addr is held stable until the current is accepted. Any number of wait cycles is allowed.
  - On acceptance, state[idx] is updated and idx increments.
  - The FSM moves to FINISH after idx = N_NEURONS-1 is accepted. Throughput is one neuron per cycle when i_cur_valid is held high.
- LIF rule (v = stored state, thr, rest, dec = configuration, I = current), applied in priority order:
  - v ≥ thr: new = rest, spike = 1. I is discarded.
  - else v ≤ rest: new = rest + I, spike = 0.
  - else: new = v − dec + I, spike = 0.
  - All comparisons are unsigned.
  - Arithmetic is done at DATA_LENGTH+2 bits signed. The result is clamped to the range [0, 2^DATA_LENGTH − 1], so there is no wraparound.
- Update output:
  - o_upd_valid is registered and appears in the cycle after acceptance.
  - It carries the address, the new state and the spike flag of that update.
- FINISH:
  - Lasts one cycle. o_done=1 and o_busy=0.
  - The final o_upd_valid pulse is in this same cycle.
  - The FSM returns to IDLE next cycle. A tick in the FINISH cycle is treated as an overrun.
- Overrun: i_tick while in FETCH or FINISH gives an o_overrun pulse in the next cycle. The tick is dropped and the sweep is unaffected.
- Configuration writes:
  - Accepted only in IDLE, and take effect on the next edge.
  - Ignored in FETCH and FINISH; no error flag is raised.
  - i_tick and i_cfg_we in the same IDLE cycle: both are applied, and the sweep uses the new value.
- Spike event: each spike is evaluated on the pre-update state, so a neuron that reaches threshold fires on the following sweep. This one-timestep delay is intentional.

Test Plan:
- Config and threshold crossing: N=4; write thr=100, rest=10, dec=5; three ticks, all currents 50, i_cur_valid held high.
  - Sweep 1: states 60, no spikes.
  - Sweep 2: states 105.
  - Sweep 3: addrs 0..3 all spike=1, state=10.
  - Each sweep has exactly 4 o_upd_valid pulses on consecutive cycles and one o_done.
- Backpressure: i_cur_valid low for 3 cycles at addr 2.
  - o_cur_addr holds at 2 and no o_upd_valid is produced during the stall.
  - The sweep finishes 3 cycles later than an unstalled sweep, with identical results.
- Overrun: i_tick pulsed during addr 1 of a sweep.
  - o_overrun pulses once.
  - Exactly N updates and one o_done occur; no second sweep starts.
- Config lockout: i_cfg_we with thr=5 mid-sweep is ignored.
  - The next sweep still uses thr=100.
  - A write of thr=5 in IDLE then takes effect.
- Saturation and underflow:
  - State 0xFFFF_FF00 with thr=max, rest=0, dec=0, I=0x1000: new state clamps to 0xFFFF_FFFF.
  - v=20, rest=10, dec=50, I=0: new state clamps to 0.
- Asynchronous reset mid-sweep: i_rst_n low between clock edges at addr 2.
  - Outputs go to 0 immediately and no o_done follows.
  - After release, the next sweep produces states rest+I (default rest 900000).
